// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of an asynchronous FIFO.
// Two requesters share the write port through round-robin arbitration. The controller
// keeps the binary and Gray write pointers and registers the full flag.
// Optional feature: define WFIFO_ALMOST_FULL_EN to add the registered wafull output.
// PTR_W defaults to `WPTR_WIDTH, normally set in parameters.vh. If that macro is not
// defined, PTR_W falls back to 8.

`ifndef WPTR_WIDTH
`define WPTR_WIDTH 8
`endif

module fifo_wr_ctrl #(
  parameter int unsigned PTR_W        = `WPTR_WIDTH,
  parameter int unsigned AFULL_THRESH = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             req0,
  input  logic             req1,
  input  logic [PTR_W-1:0] rptr_gray_sync,
  output logic             gnt0,
  output logic             gnt1,
  output logic             mem_we,
  output logic [PTR_W-2:0] waddr,
  output logic             wsel,
  output logic [PTR_W-1:0] wptr_gray,
`ifdef WFIFO_ALMOST_FULL_EN
  output logic             wfull,
  output logic             wafull
`else
  output logic             wfull
`endif
);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_d;
  logic             last_q, last_d;
  logic             wsel_q;
  logic             full_d;

  // Combinational one-hot grant; on contention the requester not served last wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!wrst && !wfull) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Pointer advance, round-robin marker, mux select and full detection
  always_comb begin
    mem_we  = gnt0 | gnt1;
    wbin_d  = mem_we ? wbin_q + PTR_W'(1) : wbin_q;
    wgray_d = wbin_d ^ (wbin_d >> 1);
    last_d  = mem_we ? gnt1 : last_q;
    // wsel follows the current grant and otherwise keeps the last granted requester
    wsel    = mem_we ? gnt1 : wsel_q;
    waddr   = wbin_q[PTR_W-2:0];
    // Full: the pointers differ only in the wrap bit. In Gray code that means the two
    // MSBs are inverted and the remaining bits are equal.
    full_d  = (wgray_d == {~rptr_gray_sync[PTR_W-1:PTR_W-2], rptr_gray_sync[PTR_W-3:0]});
  end

  // State registers with synchronous reset; last=1 lets req0 win the first contention
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q    <= '0;
      wptr_gray <= '0;
      wfull     <= 1'b0;
      last_q    <= 1'b1;
      wsel_q    <= 1'b0;
    end else begin
      wbin_q    <= wbin_d;
      wptr_gray <= wgray_d;
      wfull     <= full_d;
      last_q    <= last_d;
      wsel_q    <= wsel;
    end
  end

`ifdef WFIFO_ALMOST_FULL_EN
  localparam logic [PTR_W-1:0] Depth      = {1'b1, {(PTR_W-1){1'b0}}};
  localparam logic [PTR_W-1:0] AfullLimit = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] fill;
  logic [PTR_W-1:0] free_slots;
  logic             afull_d;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    rbin = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      rbin[i] = ^(rptr_gray_sync >> i);
    end
    fill       = wbin_d - rbin;
    free_slots = Depth - fill;
    afull_d    = (free_slots <= AfullLimit);
  end

  // Almost-full flag, refreshed every cycle
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wafull <= 1'b0;
    end else begin
      wafull <= afull_d;
    end
  end
`endif

endmodule
